apb_reset_rx: RTL
=================

APB_RESET_RX -- requirements
Module: apb_reset_rx

Interface
REQ-001 SHALL have parameter MIN_ASSERT_CYCLES, default 4, minimum local reset assertion width in pclk cycles (>=1).
REQ-002 SHALL have parameter RELEASE_DELAY, default 8, cycles local_rst is held after a qualified presetn release (>=1).
REQ-003 SHALL have parameter FILTER_STAGES, default 2, consecutive equal samples needed to accept a presetn change (>=1).
REQ-004 SHALL have parameter CNT_W, default 8, width of the reset event counter.
REQ-005 SHALL have port pclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port preset  input  1  block reset, synchronous, active-high.
REQ-007 SHALL have port presetn_in  input  1  monitored APB reset, active-low, not assumed synchronous to pclk.
REQ-008 SHALL have port err_clr  input  1  single-cycle clear of short_err.
REQ-009 SHALL have port local_rst  output  1  downstream reset, active-high, registered.
REQ-010 SHALL have port ready  output  1  high only in RUN, registered.
REQ-011 SHALL have port short_err  output  1  sticky flag: assertion shorter than MIN_ASSERT_CYCLES seen.
REQ-012 SHALL have port evt_cnt  output  CNT_W  count of qualified presetn assertions, saturating.

Function
REQ-013 SHALL pass presetn_in through a 2-flop synchronizer; the synchronizer output is sync_n.
REQ-014 SHALL update filtered presetn (filt_n) to sync_n once sync_n has differed from filt_n for FILTER_STAGES consecutive cycles; shorter excursions are discarded.
REQ-015 SHALL give end-to-end latency from the first pclk edge sampling a new presetn_in level to the filt_n change of exactly 2+FILTER_STAGES cycles.
REQ-016 SHALL implement FSM states ASSERT, STRETCH, RELEASE_WAIT, RUN.
REQ-017 SHALL count assert cycles (asrt_cnt) from 0 on ASSERT entry, incrementing each cycle in ASSERT and STRETCH and saturating at MIN_ASSERT_CYCLES.
REQ-018 ASSERT: on filt_n=1 SHALL go to RELEASE_WAIT if asrt_cnt>=MIN_ASSERT_CYCLES, else go to STRETCH and set short_err.
REQ-019 STRETCH: SHALL go to RELEASE_WAIT when asrt_cnt reaches MIN_ASSERT_CYCLES.
REQ-020 RELEASE_WAIT: SHALL count RELEASE_DELAY cycles from entry, then go to RUN.
REQ-021 SHALL enter ASSERT (asrt_cnt=0) from any state on a filt_n 1->0 transition, which takes priority over all other transitions.
REQ-022 SHALL increment evt_cnt by 1 on each filt_n 1->0 transition and saturate at 2^CNT_W-1.
REQ-023 SHALL drive local_rst=1 in every state except RUN, and ready=1 only in RUN, both registered from next-state.
REQ-024 SHALL clear short_err on err_clr; when a set and err_clr occur in the same cycle, the set SHALL win.

Reset
REQ-025 While preset=1 at a pclk edge, SHALL set the synchronizer flops, filter counter and filt_n to 0, the state to ASSERT, asrt_cnt to 0, the delay count to 0, local_rst to 1, ready to 0, short_err to 0 and evt_cnt to 0.
REQ-026 Because filt_n resets to 0, reset exit SHALL NOT produce an evt_cnt increment.
REQ-027 preset asserted in any state, including mid-RELEASE_WAIT, SHALL restore REQ-025 values on the next edge.

Verification (defaults MIN=4, DELAY=8, FILTER=2)
REQ-028 preset 2 cycles, presetn_in=0 for 10 cycles then 1 -> local_rst=1/ready=0 throughout, local_rst falls and ready rises 12 cycles after the first edge sampling 1, evt_cnt=0, short_err=0.
REQ-029 In RUN, presetn_in low for 1 cycle -> local_rst, ready and evt_cnt unchanged.
REQ-030 In RUN, presetn_in low for 3 cycles -> local_rst=1, short_err=1, evt_cnt=1, 1 STRETCH cycle then 8 RELEASE_WAIT cycles, then RUN.
REQ-031 Short pulse and err_clr in the same cycle -> short_err=1; err_clr alone later -> short_err=0.
REQ-032 presetn_in re-asserted mid-RELEASE_WAIT -> ASSERT, local_rst stays 1, evt_cnt +1; preset mid-RELEASE_WAIT -> all REQ-025 values next cycle.
REQ-033 More than 255 qualified assertions -> evt_cnt holds at 255.

Source files
------------

// File: rtl/apb_reset_rx.sv
// APB reset receiver: synchronizes and deglitches presetn_in, enforces a minimum
// local reset width and a release delay, and counts qualified reset assertions.
module apb_reset_rx #(
  parameter int MIN_ASSERT_CYCLES = 4,
  parameter int RELEASE_DELAY     = 8,
  parameter int FILTER_STAGES     = 2,
  parameter int CNT_W             = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             presetn_in,
  input  logic             err_clr,
  output logic             local_rst,
  output logic             ready,
  output logic             short_err,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int FCNT_W = $clog2(FILTER_STAGES + 1);
  localparam int ACNT_W = $clog2(MIN_ASSERT_CYCLES + 1);
  localparam int DCNT_W = $clog2(RELEASE_DELAY + 1);

  typedef enum logic [1:0] {
    ASSERT       = 2'd0,
    STRETCH      = 2'd1,
    RELEASE_WAIT = 2'd2,
    RUN          = 2'd3
  } state_t;

  logic              sync_p0;
  logic              sync_n;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_nx;
  logic              filt_n;
  logic              filt_nx;
  logic              filt_fall;

  state_t            state;
  state_t            state_nx;
  logic [ACNT_W-1:0] asrt_cnt;
  logic [ACNT_W-1:0] asrt_nx;
  logic [ACNT_W-1:0] asrt_inc;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_nx;
  logic              set_err;

  // The filter counts cycles of disagreement and commits the new level one
  // cycle after FILTER_STAGES have been seen, giving 2+FILTER_STAGES latency.
  always_comb begin
    filt_nx = filt_n;
    fcnt_nx = '0;
    if (sync_n != filt_n) begin
      if (fcnt == FCNT_W'(FILTER_STAGES)) filt_nx = sync_n;
      else                                fcnt_nx = fcnt + 1'b1;
    end
  end

  assign filt_fall = filt_n & ~filt_nx;
  assign asrt_inc  = (asrt_cnt >= ACNT_W'(MIN_ASSERT_CYCLES)) ? asrt_cnt : asrt_cnt + 1'b1;

  // The FSM reacts to the filtered level on the same edge it is committed.
  always_comb begin
    state_nx = state;
    asrt_nx  = asrt_cnt;
    dcnt_nx  = dcnt;
    set_err  = 1'b0;
    if (filt_fall) begin
      state_nx = ASSERT;
      asrt_nx  = '0;
      dcnt_nx  = '0;
    end else begin
      case (state)
        ASSERT: begin
          asrt_nx = asrt_inc;
          if (filt_nx) begin
            if (asrt_cnt >= ACNT_W'(MIN_ASSERT_CYCLES)) begin
              state_nx = RELEASE_WAIT;
              dcnt_nx  = '0;
            end else begin
              state_nx = STRETCH;
              set_err  = 1'b1;
            end
          end
        end
        STRETCH: begin
          asrt_nx = asrt_inc;
          if (asrt_inc >= ACNT_W'(MIN_ASSERT_CYCLES)) begin
            state_nx = RELEASE_WAIT;
            dcnt_nx  = '0;
          end
        end
        RELEASE_WAIT: begin
          if (dcnt == DCNT_W'(RELEASE_DELAY - 1)) state_nx = RUN;
          else                                    dcnt_nx  = dcnt + 1'b1;
        end
        RUN:     state_nx = RUN;
        default: state_nx = ASSERT;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      sync_p0   <= 1'b0;
      sync_n    <= 1'b0;
      fcnt      <= '0;
      filt_n    <= 1'b0;
      state     <= ASSERT;
      asrt_cnt  <= '0;
      dcnt      <= '0;
      local_rst <= 1'b1;
      ready     <= 1'b0;
      short_err <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      sync_p0   <= presetn_in;
      sync_n    <= sync_p0;
      fcnt      <= fcnt_nx;
      filt_n    <= filt_nx;
      state     <= state_nx;
      asrt_cnt  <= asrt_nx;
      dcnt      <= dcnt_nx;
      local_rst <= (state_nx != RUN);
      ready     <= (state_nx == RUN);
      if (set_err)      short_err <= 1'b1;
      else if (err_clr) short_err <= 1'b0;
      if (filt_fall && (evt_cnt != {CNT_W{1'b1}})) evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule
